// File: rtl/div_pkg.sv
// Shared constants, state codes and helpers for the iterative divider.
package div_pkg;

    localparam int unsigned WIDTH        = 32;
    localparam int unsigned DoubleRegBus = 2 * WIDTH;
    localparam int unsigned CNT_W        = $clog2(WIDTH) + 1;

    localparam logic RstEnable         = 1'b1;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [WIDTH-1:0] ZeroWord = WIDTH'(0);

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // HI/LO payload: remainder goes to HI, quotient to LO.
    typedef struct packed {
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] quo;
    } div_result_t;

    // Two's complement negation, modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] neg_word(input logic [WIDTH-1:0] v);
        return WIDTH'(ZeroWord - v);
    endfunction

    // Magnitude of an operand when dividing signed; raw value otherwise.
    function automatic logic [WIDTH-1:0] mag_word(input logic             is_signed,
                                                  input logic [WIDTH-1:0] v);
        return (is_signed && v[WIDTH-1]) ? neg_word(v) : v;
    endfunction

endpackage

// File: rtl/div.sv
// Iterative restoring shift-subtract divider, one quotient bit per cycle.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   signed_div_i    1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
//   opdata1_i       dividend; sampled with start
//   opdata2_i       divisor; sampled with start
//   start_i         level request, held until ready_o is seen
//   annul_i         abort an in-flight division
//   result_o        {remainder, quotient}, registered
//   ready_o         result valid, registered
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [WIDTH-1:0]        opdata1_i,
    input  logic [WIDTH-1:0]        opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH:0]     dividend_q, dividend_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    div_result_t          result_d;
    logic                 ready_d;

    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     quo_raw;
    logic [WIDTH-1:0]     rem_raw;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_o   <= '0;
            ready_o    <= DivResultNotReady;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            result_o   <= result_d;
            ready_o    <= ready_d;
        end
    end

    // Next-state, iteration step and output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        result_d   = '0;
        ready_d    = DivResultNotReady;

        // Trial subtraction on the upper window; a set MSB means it does not fit.
        diff    = {1'b0, dividend_q[2*WIDTH-1:WIDTH]} - {1'b0, divisor_q};
        quo_raw = dividend_q[WIDTH-1:0];
        rem_raw = dividend_q[2*WIDTH:WIDTH+1];

        unique case (state_q)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == ZeroWord) begin
                        state_d = DivByZero;
                    end else begin
                        state_d    = DivOn;
                        cnt_d      = '0;
                        dividend_d = {ZeroWord, mag_word(signed_div_i, opdata1_i), 1'b0};
                        divisor_d  = mag_word(signed_div_i, opdata2_i);
                        neg_quo_d  = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_d  = signed_div_i & opdata1_i[WIDTH-1];
                    end
                end
            end

            DivByZero: begin
                dividend_d = '0;
                state_d    = DivEnd;
            end

            DivOn: begin
                if (annul_i) begin
                    state_d = DivFree;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_W'(WIDTH)) begin
                    if (diff[WIDTH]) begin
                        dividend_d = {dividend_q[2*WIDTH-1:0], 1'b0};
                    end else begin
                        dividend_d = {diff[WIDTH-1:0], dividend_q[WIDTH-1:0], 1'b1};
                    end
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end else begin
                    // Quotient sign follows the operand signs, remainder follows the dividend.
                    result_d.quo = neg_quo_q ? neg_word(quo_raw) : quo_raw;
                    result_d.rem = neg_rem_q ? neg_word(rem_raw) : rem_raw;
                    ready_d      = DivResultReady;
                    state_d      = DivEnd;
                    cnt_d        = '0;
                end
            end

            DivEnd: begin
                if (start_i == DivStop) begin
                    state_d = DivFree;
                end else begin
                    result_d = result_o;
                    ready_d  = DivResultReady;
                end
            end

            default: state_d = DivFree;
        endcase
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: cycle-level reference model plus directed cases.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: truncating division, remainder takes dividend sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sg);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Latency-based model: phase 0 idle, 1 busy (countdown), 2 result held.
    int          ph = 0;
    int          cd = 0;
    bit          dbz = 1'b0;
    logic [63:0] pend = '0;
    logic        exp_ready = 1'b0;
    logic [63:0] exp_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            ph        <= 0;
            exp_ready <= 1'b0;
            exp_res   <= '0;
        end else begin
            case (ph)
                0: begin
                    exp_ready <= 1'b0;
                    exp_res   <= '0;
                    if (start_i && !annul_i) begin
                        pend <= ref_div(opdata1_i, opdata2_i, signed_div_i);
                        dbz  <= (opdata2_i == 32'd0);
                        cd   <= (opdata2_i == 32'd0) ? 2 : 33;
                        ph   <= 1;
                    end
                end
                1: begin
                    if (!dbz && annul_i) begin
                        ph <= 0;
                    end else begin
                        cd <= cd - 1;
                        if (cd == 1) begin
                            if (dbz && !start_i) begin
                                ph <= 0;
                            end else begin
                                ph        <= 2;
                                exp_ready <= 1'b1;
                                exp_res   <= pend;
                            end
                        end
                    end
                end
                default: begin
                    if (!start_i) begin
                        ph        <= 0;
                        exp_ready <= 1'b0;
                        exp_res   <= '0;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (chk_en) begin
            checks++;
            if (ready_o !== exp_ready || result_o !== exp_res) begin
                errors++;
                $display("FAIL model cycle %0d: ready_o=%b result_o=%h expected ready_o=%b result_o=%h",
                         cyc, ready_o, result_o, exp_ready, exp_res);
            end
        end
    end

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for ready_o; optionally scrambles inputs that the busy divider must ignore.
    task automatic wait_ready(input bit scramble, output int lat);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (ready_o) begin
                lat = n - 1;
                break;
            end
            if (scramble) begin
                if (n < 25) begin
                    opdata1_i    = $urandom;
                    opdata2_i    = $urandom;
                    signed_div_i = 1'($urandom);
                    start_i      = 1'($urandom);
                end else begin
                    start_i = 1'b1;
                end
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: no ready_o within 60 cycles");
        end
    endtask

    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sg, input logic [63:0] exp_r, input int hold,
                           input bit scramble);
        int lat;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sg;
        start_i      = 1'b1;
        wait_ready(scramble && (b != 32'd0), lat);
        check_val({name, " latency"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
        check_val({name, " result"}, result_o, exp_r);
        repeat (hold) @(negedge clk);
        check_val({name, " ready held"}, 64'(ready_o), 64'd1);
        check_val({name, " result held"}, result_o, exp_r);
        start_i = 1'b0;
        @(negedge clk);
        check_val({name, " ready drop"}, 64'(ready_o), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        sg;
        int          lat;

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check_val("reset ready", 64'(ready_o), 64'd0);
        check_val("reset result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_div("udiv 100/7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 0, 1'b0);
        run_div("sdiv -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1, 1'b0);
        run_div("sdiv 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 0, 1'b0);
        run_div("sdiv min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 0, 1'b0);
        run_div("udiv min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'd0}, 0, 1'b0);
        run_div("div 5/0", 32'd5, 32'd0, 1'b0, 64'd0, 5, 1'b0);

        // Annul after ten iterations, then a fresh 7/7 the following cycle.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        check_val("annul no ready", 64'(ready_o), 64'd0);
        opdata1_i = 32'd7;
        opdata2_i = 32'd7;
        wait_ready(1'b0, lat);
        check_val("after annul latency", 64'(lat), 64'd33);
        check_val("after annul result", result_o, {32'd0, 32'd1});
        start_i = 1'b0;
        @(negedge clk);

        // Reset at iteration twenty aborts; the next cycle accepts a new start.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid reset ready", 64'(ready_o), 64'd0);
        check_val("mid reset result", result_o, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        run_div("udiv 9/2", 32'd9, 32'd2, 1'b0, {32'd1, 32'd4}, 0, 1'b0);

        // Operand and start changes during the run must not matter.
        run_div("scrambled 1000/3", 32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 2, 1'b1);

        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            sg = 1'($urandom);
            case ($urandom % 8)
                0:       b = 32'd0;
                1:       b = 32'($urandom % 16);
                2:       b = 32'hFFFF_FFFF;
                default: b = 32'($urandom) >> ($urandom % 32);
            endcase
            if ($urandom % 6 == 0) a = 32'h8000_0000;
            run_div($sformatf("random %0d", i), a, b, sg, ref_div(a, b, sg),
                    int'($urandom % 4), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div.md
# div

Iterative 32-bit signed/unsigned divider serving the execute stage, which consumes operands from the ID/EX register. The execute stage starts a division for DIV/DIVU, stalls the pipeline while the divider runs, and writes the 64-bit result into HI/LO. The divider uses a restoring shift-subtract algorithm and produces one quotient bit per cycle. Result is {remainder, quotient}.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high (`RstEnable` = 1'b1).
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1_i  input  WIDTH  dividend; sampled with start.
- opdata2_i  input  WIDTH  divisor; sampled with start.
- start_i  input  1  request; level, held by EX until ready_o seen.
- annul_i  input  1  abort in-flight division (branch/exception flush).
- result_o  output  2*WIDTH  [63:32] remainder (to HI), [31:0] quotient (to LO); registered.
- ready_o  output  1  result valid; registered.

## Operation
- States, with codes in defs.v: DivFree, DivByZero, DivOn, DivEnd.
- DivFree:
  - start_i=1, annul_i=0, divisor=0 → DivByZero.
  - start_i=1, annul_i=0, divisor≠0 → DivOn with cnt=0. Load dividend register (2*WIDTH+1 bits) = {0, |op1|, 0} and latch |op2|. Absolute values are used only when signed_div_i=1; otherwise operands are used raw.
  - Otherwise stay. ready_o=0, result_o=0.
- DivByZero → DivEnd unconditionally. Result = 0.
- DivOn:
  - annul_i=1 → DivFree, cnt cleared, no result.
  - Else if cnt<WIDTH: diff = upper(WIDTH+1 bits) − divisor.
    - diff negative: shift left, insert 0.
    - Else: dividend = {diff[WIDTH-1:0], lower bits, 1}.
    - cnt++.
  - Else (cnt==WIDTH): apply sign fix, load result_o, ready_o=1, → DivEnd.
- Sign fix (signed only):
  - Quotient is negated when op1[31]^op2[31].
  - Remainder is negated when op1[31], so remainder takes the dividend's sign.
  - All arithmetic is two's complement modulo 2^WIDTH. 0x80000000/0xFFFFFFFF signed yields quotient 0x80000000, remainder 0.
- DivEnd:
  - start_i=0 → DivFree, ready_o=0, result_o=0.
  - start_i=1 → hold result and ready_o.
- start_i is ignored in DivOn and DivByZero; operands are not re-sampled.
- Operand changes after the start sample have no effect.
- annul_i is ignored in DivFree (no start), DivByZero, and DivEnd.
- cnt width is clog2(WIDTH)+1.

## Timing
- Reset: state=DivFree, cnt=0, ready_o=0, result_o=0, internal registers 0. Reset mid-division aborts with no result; the next cycle accepts a new start.
- Start sampled at edge E.
  - Normal division: iterations occur at edges E+1..E+WIDTH; ready_o rises after edge E+WIDTH+1 (33 for WIDTH=32).
  - Divide by zero: ready_o rises after edge E+2.
- ready_o stays high while start_i stays high. It falls on the first edge after start_i drops.
- A new start is accepted one cycle after returning to DivFree. Minimum gap between results is therefore 2 cycles beyond latency.
- Annul at edge A during DivOn: state is DivFree after A; ready_o never asserts.

## Structure
- defs.v:
  - State codes: DivFree, DivByZero, DivOn, DivEnd.
  - DivStart/DivStop, DivResultReady/DivResultNotReady, DoubleRegBus, ZeroWord.
- Single flat module. No sub-module: the subtract/shift datapath is too small to split.

## Test plan
- Unsigned 100/7: start, wait → ready_o after 33 cycles, result_o={32'd2, 32'd14}.
- Signed −7/2 (0xFFFFFFF9/2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/−2 → quotient 0xFFFFFFFD, remainder 1. Also check 0x80000000/0xFFFFFFFF signed → quotient 0x80000000, remainder 0.
- Divide by zero (5/0) → ready_o exactly 2 cycles after start sample, result_o=0. Hold start 5 cycles → ready_o stays 1; drop start → ready_o=0 next cycle.
- annul_i pulsed at iteration 10 → no ready_o; a new start 7/7 next cycle → result {0,1} after 33 cycles.
- rst asserted at iteration 20 → outputs 0 next cycle. Toggle start_i and operands mid-run (no annul) → result unchanged from originally sampled operands.
